// File: rtl/dual_mult_accum.sv
// Per-lane accumulate/bias/requantize stage behind dsp_dual_mult.
// Sums KERNEL_LEN products per lane, rounds, optionally ReLUs, saturates, and holds the result until accepted.
module dual_mult_accum #(
  parameter int KERNEL_LEN = 9,
  parameter int ACC_W      = 32,
  parameter int SHIFT      = 8,
  parameter int OUT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [15:0]      ac,
  input  logic signed [15:0]      bc,
  input  logic                    valid_in,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] bias_a,
  input  logic signed [ACC_W-1:0] bias_b,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] out_a,
  output logic signed [OUT_W-1:0] out_b,
  output logic                    valid_out,
  input  logic                    out_ready,
  output logic                    drop_err
);

  localparam int CNT_W  = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(KERNEL_LEN - 1);
  localparam logic signed [ACC_W-1:0] RND      = (SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0] acc_b_q, acc_b_d;
  logic signed [ACC_W-1:0] bias_a_q, bias_a_d;
  logic signed [ACC_W-1:0] bias_b_q, bias_b_d;
  logic signed [OUT_W-1:0] out_a_q, out_a_d;
  logic signed [OUT_W-1:0] out_b_q, out_b_d;
  logic                    valid_out_q, valid_out_d;
  logic                    in_ready_q, in_ready_d;
  logic                    drop_err_q, drop_err_d;
  logic                    accept;

  function automatic logic signed [ACC_W-1:0] sext16(input logic signed [15:0] p);
    return {{(ACC_W-16){p[15]}}, p};
  endfunction

  // Round-half-up then floor shift; RND is zero when SHIFT is zero, so this degenerates to pass-through.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] t;
    t = s + RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] r_in,
                                                        input logic relu);
    logic signed [ACC_W-1:0] r;
    r = r_in;
    if (relu && (r < 0)) begin
      r = '0;
    end
    if (r > SAT_HI) begin
      r = SAT_HI;
    end else if (r < SAT_LO) begin
      r = SAT_LO;
    end
    return r[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                                       input logic signed [ACC_W-1:0] bias,
                                                       input logic relu);
    return relu_sat(round_shift(acc + bias), relu);
  endfunction

  assign accept = valid_in && in_ready_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    bias_a_d    = bias_a_q;
    bias_b_d    = bias_b_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    valid_out_d = valid_out_q;
    drop_err_d  = drop_err_q;

    if (valid_in && !in_ready_q) begin
      drop_err_d = 1'b1;
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_a_d = acc_a_q + sext16(ac);
          acc_b_d = acc_b_q + sext16(bc);
          if (count_q == '0) begin
            bias_a_d = bias_a;
            bias_b_d = bias_b;
          end
          if (count_q == CNT_LAST) begin
            count_d = '0;
            state_d = FINAL;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      FINAL: begin
        out_a_d     = requant(acc_a_q, bias_a_q, relu_en);
        out_b_d     = requant(acc_b_q, bias_b_q, relu_en);
        valid_out_d = 1'b1;
        acc_a_d     = '0;
        acc_b_d     = '0;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_out_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    // in_ready is registered; it reads low in reset and rises on the first edge after release.
    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      bias_a_q    <= '0;
      bias_b_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      valid_out_q <= 1'b0;
      in_ready_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      bias_a_q    <= bias_a_d;
      bias_b_q    <= bias_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      valid_out_q <= valid_out_d;
      in_ready_q  <= in_ready_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign valid_out = valid_out_q;
  assign drop_err  = drop_err_q;

endmodule
